// File: rtl/stack_cpu_pkg.sv
// Shared definitions for the parametrised stack-machine core: opcodes, fault codes,
// FSM states and instruction field positions.
package stack_cpu_pkg;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_SUB  = 8'h02;
  localparam logic [7:0] OP_DUP  = 8'h03;
  localparam logic [7:0] OP_SWAP = 8'h04;
  localparam logic [7:0] OP_ROT  = 8'h05;
  localparam logic [7:0] OP_RET  = 8'h06;
  localparam logic [7:0] OP_LT   = 8'h07;
  localparam logic [7:0] OP_GT   = 8'h08;
  localparam logic [7:0] OP_EQ   = 8'h09;
  localparam logic [7:0] OP_NEG  = 8'h0A;
  localparam logic [7:0] OP_OUT  = 8'h0B;
  localparam logic [7:0] OP_DROP = 8'h0C;
  localparam logic [7:0] OP_AND  = 8'h0D;
  localparam logic [7:0] OP_OR   = 8'h0E;
  localparam logic [7:0] OP_XOR  = 8'h0F;
  localparam logic [7:0] OP_HALT = 8'h1F;

  localparam logic [2:0] F_NONE     = 3'd0;
  localparam logic [2:0] F_DUNDER   = 3'd1;
  localparam logic [2:0] F_DOVER    = 3'd2;
  localparam logic [2:0] F_RUNDER   = 3'd3;
  localparam logic [2:0] F_ROVER    = 3'd4;
  localparam logic [2:0] F_MISALIGN = 3'd5;
  localparam logic [2:0] F_ILLEGAL  = 3'd6;

  // Word-instruction fields: bit 15 literal flag, KIND in [14:13], IMM in [14:0], OFF13 in [12:0]
  localparam int IMM_W   = 15;
  localparam int OFF_W   = 13;
  localparam int KIND_HI = 14;
  localparam int KIND_LO = 13;

  localparam logic [1:0] K_JUMP  = 2'b01;
  localparam logic [1:0] K_CALL  = 2'b10;
  localparam logic [1:0] K_CJUMP = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH,
    S_WORD,
    S_BYTE,
    S_OUT_WAIT,
    S_HALT
  } state_t;

endpackage

// File: rtl/stack_file.sv
// LIFO register file with push/pop and up to three in-place replacements addressed
// relative to the top after any pop in the same cycle.
module stack_file #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  input  logic [2:0]                 i_replace,
  input  logic [WIDTH-1:0]           i_rep_tos,
  input  logic [WIDTH-1:0]           i_rep_nos,
  input  logic [WIDTH-1:0]           i_rep_third,
  output logic [WIDTH-1:0]           o_tos,
  output logic [WIDTH-1:0]           o_nos,
  output logic [WIDTH-1:0]           o_third,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Padded to a power of two so invalid (fault-guarded) indices never leave the array
  logic [WIDTH-1:0] r_mem [0:(1<<IW)-1];
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_base;

  assign w_base  = i_pop ? r_count - CW'(1) : r_count;
  assign o_tos   = r_mem[IW'(r_count - CW'(1))];
  assign o_nos   = r_mem[IW'(r_count - CW'(2))];
  assign o_third = r_mem[IW'(r_count - CW'(3))];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

  always_ff @(posedge clk) begin
    if (rst) r_count <= '0;
    else if (i_push && !i_pop) r_count <= r_count + CW'(1);
    else if (i_pop && !i_push) r_count <= r_count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (i_push)       r_mem[IW'(r_count)]          <= i_push_data;
    if (i_replace[0]) r_mem[IW'(w_base - CW'(1))] <= i_rep_tos;
    if (i_replace[1]) r_mem[IW'(w_base - CW'(2))] <= i_rep_nos;
    if (i_replace[2]) r_mem[IW'(w_base - CW'(3))] <= i_rep_third;
  end

endmodule

// File: rtl/stack_cpu_param.sv
// Parametrised 16-bit-instruction stack machine: word ops (literal/jump/call/cjump),
// two packed byte ops per word, ready/valid output port and fault-to-halt.
module stack_cpu_param
  import stack_cpu_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 15,
  parameter int DSTACK_DEPTH = 16,
  parameter int RSTACK_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic                              imem_req,
  output logic [ADDR_W-1:0]                 imem_addr,
  input  logic                              imem_valid,
  input  logic [15:0]                       imem_data,
  output logic [DATA_W-1:0]                 out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              halted,
  output logic [2:0]                        fault,
  output logic [$clog2(DSTACK_DEPTH+1)-1:0] dsp
);
  localparam int IPW = ADDR_W + 1;
  localparam int DCW = $clog2(DSTACK_DEPTH + 1);
  localparam int RCW = $clog2(RSTACK_DEPTH + 1);

  state_t            r_state;
  logic [IPW-1:0]    r_ip;
  logic [15:0]       r_ir;
  logic              r_imem_req, r_out_valid, r_halted;
  logic [DATA_W-1:0] r_out_data;
  logic [2:0]        r_fault;

  logic [DATA_W-1:0] w_tos, w_nos, w_third, w_d_push_val, w_rep_tos, w_rep_nos, w_rep_third;
  logic [DCW-1:0]    w_d_cnt;
  logic              w_d_full, w_d_empty, w_d_push, w_d_pop;
  logic [2:0]        w_d_rep;
  logic [IPW-1:0]    w_r_tos, w_unused_r_nos, w_unused_r_third, w_ip_next, w_ip_rel;
  logic [RCW-1:0]    w_unused_r_cnt;
  logic              w_r_full, w_r_empty, w_r_push, w_r_pop, w_do_out;
  logic [2:0]        w_fault_code;
  logic [7:0]        w_op;
  state_t            w_next_state;

  assign imem_req  = r_imem_req;
  assign imem_addr = r_ip[ADDR_W:1];
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign halted    = r_halted;
  assign fault     = r_fault;
  assign dsp       = w_d_cnt;

  assign w_op     = r_ip[0] ? r_ir[7:0] : r_ir[15:8];
  assign w_ip_rel = r_ip + {{(IPW-OFF_W){r_ir[OFF_W-1]}}, r_ir[OFF_W-1:0]} + IPW'(2);

  always_comb begin
    w_fault_code = F_NONE;
    w_d_push     = 1'b0;
    w_d_push_val = w_tos;
    w_d_pop      = 1'b0;
    w_d_rep      = 3'b000;
    w_rep_tos    = w_tos;
    w_rep_nos    = w_nos;
    w_rep_third  = w_third;
    w_r_push     = 1'b0;
    w_r_pop      = 1'b0;
    w_do_out     = 1'b0;
    w_ip_next    = r_ip;
    w_next_state = r_state;
    if (r_state == S_WORD) begin
      w_ip_next    = r_ip + IPW'(2);
      w_next_state = S_FETCH;
      if (r_ip[0]) w_fault_code = F_MISALIGN;
      else if (r_ir[15]) begin
        if (w_d_full) w_fault_code = F_DOVER;
        else begin
          w_d_push     = 1'b1;
          w_d_push_val = {{(DATA_W-IMM_W){1'b0}}, r_ir[IMM_W-1:0]};
        end
      end else begin
        case (r_ir[KIND_HI:KIND_LO])
          K_JUMP: w_ip_next = w_ip_rel;
          K_CALL: begin
            if (w_r_full) w_fault_code = F_ROVER;
            else begin
              w_r_push  = 1'b1;
              w_ip_next = w_ip_rel;
            end
          end
          K_CJUMP: begin
            if (w_d_empty) w_fault_code = F_DUNDER;
            else begin
              w_d_pop = 1'b1;
              if (w_tos == '0) w_ip_next = w_ip_rel;
            end
          end
          default: ;
        endcase
      end
    end else if (r_state == S_BYTE) begin
      w_ip_next    = r_ip + IPW'(1);
      w_next_state = r_ip[0] ? S_FETCH : S_BYTE;
      case (w_op)
        OP_NOP: ;
        OP_ADD, OP_SUB, OP_LT, OP_GT, OP_EQ, OP_AND, OP_OR, OP_XOR: begin
          if (w_d_cnt < DCW'(2)) w_fault_code = F_DUNDER;
          w_d_pop = 1'b1;
          w_d_rep = 3'b001;
          case (w_op)
            OP_ADD:  w_rep_tos = w_nos + w_tos;
            OP_SUB:  w_rep_tos = w_nos - w_tos;
            OP_LT:   w_rep_tos = {DATA_W{w_nos < w_tos}};
            OP_GT:   w_rep_tos = {DATA_W{w_nos > w_tos}};
            OP_EQ:   w_rep_tos = {DATA_W{w_nos == w_tos}};
            OP_AND:  w_rep_tos = w_nos & w_tos;
            OP_OR:   w_rep_tos = w_nos | w_tos;
            default: w_rep_tos = w_nos ^ w_tos;
          endcase
        end
        OP_DUP: begin
          if (w_d_empty) w_fault_code = F_DUNDER;
          else if (w_d_full) w_fault_code = F_DOVER;
          w_d_push = 1'b1;
        end
        OP_SWAP: begin
          if (w_d_cnt < DCW'(2)) w_fault_code = F_DUNDER;
          w_d_rep   = 3'b011;
          w_rep_tos = w_nos;
          w_rep_nos = w_tos;
        end
        OP_ROT: begin
          if (w_d_cnt < DCW'(3)) w_fault_code = F_DUNDER;
          w_d_rep     = 3'b111;
          w_rep_tos   = w_third;
          w_rep_nos   = w_tos;
          w_rep_third = w_nos;
        end
        OP_RET: begin
          if (w_r_empty) w_fault_code = F_RUNDER;
          w_r_pop      = 1'b1;
          w_ip_next    = w_r_tos;
          w_next_state = S_FETCH;
        end
        OP_NEG: begin
          if (w_d_empty) w_fault_code = F_DUNDER;
          w_d_rep   = 3'b001;
          w_rep_tos = ~w_tos;
        end
        OP_OUT: begin
          if (w_d_empty) w_fault_code = F_DUNDER;
          w_d_pop      = 1'b1;
          w_do_out     = 1'b1;
          w_next_state = S_OUT_WAIT;
        end
        OP_DROP: begin
          if (w_d_empty) w_fault_code = F_DUNDER;
          w_d_pop = 1'b1;
        end
        OP_HALT: w_next_state = S_HALT;
        default: w_fault_code = F_ILLEGAL;
      endcase
    end
    // A faulting instruction must leave ip and both stacks untouched
    if (w_fault_code != F_NONE) begin
      w_d_push  = 1'b0;
      w_d_pop   = 1'b0;
      w_d_rep   = 3'b000;
      w_r_push  = 1'b0;
      w_r_pop   = 1'b0;
      w_do_out  = 1'b0;
      w_ip_next = r_ip;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_ip        <= '0;
      r_ir        <= '0;
      r_imem_req  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_halted    <= 1'b0;
      r_fault     <= F_NONE;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (!r_imem_req) r_imem_req <= 1'b1;
          else if (imem_valid) begin
            r_ir       <= imem_data;
            r_imem_req <= 1'b0;
            r_state    <= (imem_data[15:13] != 3'b000) ? S_WORD : S_BYTE;
          end
        end
        S_WORD, S_BYTE: begin
          if (w_fault_code != F_NONE) begin
            r_fault  <= w_fault_code;
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else begin
            r_ip       <= w_ip_next;
            r_state    <= w_next_state;
            r_imem_req <= (w_next_state == S_FETCH);
            if (w_next_state == S_HALT) r_halted <= 1'b1;
            if (w_do_out) begin
              r_out_data  <= w_tos;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_OUT_WAIT: begin
          // ip already points past the OUT byte; odd ip means the low byte is still pending
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= r_ip[0] ? S_BYTE : S_FETCH;
            r_imem_req  <= !r_ip[0];
          end
        end
        default: ;
      endcase
    end
  end

  stack_file #(.WIDTH(DATA_W), .DEPTH(DSTACK_DEPTH)) u_dstack (
    .clk(clk), .rst(rst),
    .i_push(w_d_push), .i_push_data(w_d_push_val), .i_pop(w_d_pop),
    .i_replace(w_d_rep), .i_rep_tos(w_rep_tos), .i_rep_nos(w_rep_nos), .i_rep_third(w_rep_third),
    .o_tos(w_tos), .o_nos(w_nos), .o_third(w_third),
    .o_count(w_d_cnt), .o_full(w_d_full), .o_empty(w_d_empty)
  );

  stack_file #(.WIDTH(IPW), .DEPTH(RSTACK_DEPTH)) u_rstack (
    .clk(clk), .rst(rst),
    .i_push(w_r_push), .i_push_data(r_ip + IPW'(2)), .i_pop(w_r_pop),
    .i_replace(3'b000), .i_rep_tos('0), .i_rep_nos('0), .i_rep_third('0),
    .o_tos(w_r_tos), .o_nos(w_unused_r_nos), .o_third(w_unused_r_third),
    .o_count(w_unused_r_cnt), .o_full(w_r_full), .o_empty(w_r_empty)
  );

endmodule

// File: tb/tb_stack_cpu_param.sv
// Bench for stack_cpu_param: directed programs plus random programs checked against
// an instruction-level interpreter of the machine.
module tb_stack_cpu_param;
  localparam int DW = 16;
  localparam int AW = 15;
  localparam int DD = 4;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req, imem_valid = 1'b0;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_data = '0;
  logic [DW-1:0] out_data;
  logic          out_valid, out_ready = 1'b1, halted;
  logic [2:0]    fault;
  logic [$clog2(DD+1)-1:0] dsp;

  int n_checks = 0;
  int n_errors = 0;
  bit rand_ready = 1'b0;
  bit force_low  = 1'b0;

  logic [15:0] prog [0:63];
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_q[$];

  logic [15:0] m_ds[$];
  logic [15:0] m_rs[$];
  logic [15:0] m_ip;
  logic [2:0]  m_fault;
  bit          m_done;

  stack_cpu_param #(.DATA_W(DW), .ADDR_W(AW), .DSTACK_DEPTH(DD), .RSTACK_DEPTH(RD)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .halted(halted),
    .fault(fault), .dsp(dsp)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [14:0] a);
    return (a < 15'd64) ? prog[a[5:0]] : 16'h1F00;
  endfunction

  // memory responder, output sink and transfer monitor
  initial begin
    forever begin
      @(negedge clk);
      imem_valid = imem_req && ($urandom_range(0, 3) != 0);
      imem_data  = imem_valid ? mem_word(imem_addr) : 16'($urandom);
      out_ready  = force_low ? 1'b0 : (rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1);
      if (!rst && out_valid && out_ready) got_q.push_back(out_data);
    end
  end

  // driver tasks
  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = 16'h1F00;
  endtask

  task automatic run_prog(input int budget, output bit timed_out);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    got_q.delete();
    rst = 1'b0;
    timed_out = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (halted) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  // reference interpreter
  task automatic m_byte(input logic [7:0] b, output bit end_word);
    logic [15:0] t, n, th;
    int sz;
    sz = m_ds.size();
    end_word = 1'b0;
    case (b)
      8'h00: ;
      8'h01, 8'h02, 8'h07, 8'h08, 8'h09, 8'h0D, 8'h0E, 8'h0F: begin
        if (sz < 2) m_fault = 3'd1;
        else begin
          t = m_ds.pop_back();
          n = m_ds.pop_back();
          case (b)
            8'h01:   m_ds.push_back(n + t);
            8'h02:   m_ds.push_back(n - t);
            8'h07:   m_ds.push_back((n < t) ? 16'hFFFF : 16'h0000);
            8'h08:   m_ds.push_back((n > t) ? 16'hFFFF : 16'h0000);
            8'h09:   m_ds.push_back((n == t) ? 16'hFFFF : 16'h0000);
            8'h0D:   m_ds.push_back(n & t);
            8'h0E:   m_ds.push_back(n | t);
            default: m_ds.push_back(n ^ t);
          endcase
        end
      end
      8'h03: if (sz < 1) m_fault = 3'd1; else if (sz == DD) m_fault = 3'd2; else m_ds.push_back(m_ds[sz-1]);
      8'h04: if (sz < 2) m_fault = 3'd1;
             else begin t = m_ds[sz-1]; m_ds[sz-1] = m_ds[sz-2]; m_ds[sz-2] = t; end
      8'h05: if (sz < 3) m_fault = 3'd1;
             else begin
               t = m_ds[sz-1]; n = m_ds[sz-2]; th = m_ds[sz-3];
               m_ds[sz-1] = th; m_ds[sz-2] = t; m_ds[sz-3] = n;
             end
      8'h06: if (m_rs.size() == 0) m_fault = 3'd3; else m_ip = m_rs.pop_back();
      8'h0A: if (sz < 1) m_fault = 3'd1; else m_ds[sz-1] = ~m_ds[sz-1];
      8'h0B: if (sz < 1) m_fault = 3'd1; else exp_q.push_back(m_ds.pop_back());
      8'h0C: if (sz < 1) m_fault = 3'd1; else t = m_ds.pop_back();
      8'h1F: m_done = 1'b1;
      default: m_fault = 3'd6;
    endcase
    if (m_fault != 3'd0) m_done = 1'b1;
    if (m_done || b == 8'h06) end_word = 1'b1;
    else begin
      m_ip = m_ip + 16'd1;
      end_word = (m_ip[0] == 1'b0);
    end
  endtask

  task automatic m_word(input logic [15:0] w);
    logic [15:0] tgt, t;
    tgt = m_ip + {{3{w[12]}}, w[12:0]} + 16'd2;
    if (m_ip[0]) m_fault = 3'd5;
    else if (w[15]) begin
      if (m_ds.size() == DD) m_fault = 3'd2;
      else begin m_ds.push_back({1'b0, w[14:0]}); m_ip = m_ip + 16'd2; end
    end else begin
      case (w[14:13])
        2'b01: m_ip = tgt;
        2'b10: if (m_rs.size() == RD) m_fault = 3'd4;
               else begin m_rs.push_back(m_ip + 16'd2); m_ip = tgt; end
        default: if (m_ds.size() == 0) m_fault = 3'd1;
                 else begin t = m_ds.pop_back(); m_ip = (t == 16'd0) ? tgt : m_ip + 16'd2; end
      endcase
    end
    if (m_fault != 3'd0) m_done = 1'b1;
  endtask

  task automatic model_run();
    logic [15:0] w;
    bit ew;
    int steps;
    m_ds.delete(); m_rs.delete(); exp_q.delete();
    m_ip = '0; m_fault = '0; m_done = 1'b0; steps = 0;
    while (!m_done && steps < 300) begin
      w = mem_word(m_ip[15:1]);
      steps++;
      if (w[15:13] != 3'b000) m_word(w);
      else begin
        ew = 1'b0;
        while (!ew) begin
          m_byte(m_ip[0] ? w[7:0] : w[15:8], ew);
          steps++;
        end
      end
    end
  endtask

  function automatic logic [7:0] pick_byte();
    int r;
    r = $urandom_range(0, 19);
    if (r < 16) return 8'(r);
    if (r < 18) return 8'h0B;
    if (r == 18) return 8'h1F;
    return 8'h12;
  endfunction

  function automatic logic [15:0] pick_word();
    int r;
    logic [12:0] off;
    r = $urandom_range(0, 9);
    off = ($urandom_range(0, 7) == 0) ? 13'(2 * $urandom_range(0, 1) + 1) : 13'(2 * $urandom_range(0, 3));
    case (r)
      0, 1:    return 16'h8000 | 16'($urandom_range(0, 3));
      2, 3:    return 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
      4:       return {3'b001, off};
      5:       return {3'b010, off};
      6:       return {3'b011, off};
      default: return {pick_byte(), pick_byte()};
    endcase
  endfunction

  // scenario tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL reset_imem_req: got %0b want 0", imem_req); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_checks++; if (out_data !== '0) begin n_errors++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
    n_checks++; if (halted !== 1'b0) begin n_errors++; $display("FAIL reset_halted: got %0b want 0", halted); end
    n_checks++; if (fault !== 3'd0) begin n_errors++; $display("FAIL reset_fault: got %0d want 0", fault); end
    n_checks++; if (dsp !== '0) begin n_errors++; $display("FAIL reset_dsp: got %0d want 0", dsp); end
    n_checks++; if (imem_addr !== '0) begin n_errors++; $display("FAIL reset_imem_addr: got %0h want 0", imem_addr); end
  endtask

  task automatic test_directed(input string name, input logic [15:0] w0, w1, w2, w3, w4,
                               input bit has_out, input logic [DW-1:0] exp_out,
                               input logic [2:0] exp_fault, input int exp_dsp, input int exp_addr);
    bit to;
    clear_prog();
    prog[0] = w0; prog[1] = w1; prog[2] = w2; prog[3] = w3; prog[4] = w4;
    run_prog(2000, to);
    n_checks++; if (to) begin n_errors++; $display("FAIL %s_halt_timeout: core never halted", name); end
    n_checks++; if (fault !== exp_fault) begin n_errors++; $display("FAIL %s_fault: got %0d want %0d", name, fault, exp_fault); end
    n_checks++; if (dsp !== 3'(exp_dsp)) begin n_errors++; $display("FAIL %s_dsp: got %0d want %0d", name, dsp, exp_dsp); end
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL %s_imem_req: got %0b want 0", name, imem_req); end
    n_checks++;
    if (got_q.size() != (has_out ? 1 : 0) || (has_out && got_q[0] !== exp_out)) begin
      n_errors++;
      $display("FAIL %s_out: got %0d values (first %0h) want %0d values (%0h)", name, got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 16'h0, has_out ? 1 : 0, exp_out);
    end
    if (exp_addr >= 0) begin
      n_checks++; if (imem_addr !== AW'(exp_addr)) begin n_errors++; $display("FAIL %s_addr: got %0h want %0h", name, imem_addr, exp_addr); end
    end
  endtask

  task automatic test_out_stall_reset();
    bit seen;
    clear_prog();
    prog[0] = 16'h8005; prog[1] = 16'h0B1F;
    force_low = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
    end
    n_checks++; if (!seen) begin n_errors++; $display("FAIL stall_out_valid_timeout: out_valid never rose"); end
    for (int cyc = 1; cyc <= 3; cyc++) begin
      if (cyc > 1) @(negedge clk);
      n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL stall_valid_c%0d: got %0b want 1", cyc, out_valid); end
      n_checks++; if (out_data !== 16'd5) begin n_errors++; $display("FAIL stall_data_c%0d: got %0h want 5", cyc, out_data); end
      n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL stall_req_c%0d: got %0b want 0", cyc, imem_req); end
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_out_valid: got %0b want 0", out_valid); end
    n_checks++; if (imem_addr !== '0) begin n_errors++; $display("FAIL midrst_addr: got %0h want 0", imem_addr); end
    n_checks++; if (dsp !== '0) begin n_errors++; $display("FAIL midrst_dsp: got %0d want 0", dsp); end
    rst = 1'b0;
    force_low = 1'b0;
  endtask

  task automatic test_random(input int n_progs);
    bit to, bad;
    rand_ready = 1'b1;
    for (int p = 0; p < n_progs; p++) begin
      clear_prog();
      for (int i = 0; i < 20; i++) prog[i] = pick_word();
      model_run();
      if (!m_done) begin
        prog[0] = 16'h1F00;
        model_run();
      end
      run_prog(4000, to);
      n_checks++; if (to) begin n_errors++; $display("FAIL rnd%0d_timeout: core never halted", p); end
      n_checks++; if (fault !== m_fault) begin n_errors++; $display("FAIL rnd%0d_fault: got %0d want %0d", p, fault, m_fault); end
      n_checks++; if (dsp !== 3'(m_ds.size())) begin n_errors++; $display("FAIL rnd%0d_dsp: got %0d want %0d", p, dsp, m_ds.size()); end
      bad = (got_q.size() != exp_q.size());
      for (int i = 0; i < got_q.size() && !bad; i++) if (got_q[i] !== exp_q[i]) bad = 1'b1;
      n_checks++; if (bad) begin n_errors++; $display("FAIL rnd%0d_outputs: got %0d values want %0d values", p, got_q.size(), exp_q.size()); end
    end
    rand_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed("out_basic", 16'h8005, 16'h8003, 16'h020B, 16'h1F00, 16'h1F00, 1'b1, 16'd2, 3'd0, 0, -1);
    test_directed("cjump",     16'h8000, 16'h6002, 16'h800A, 16'h8009, 16'h0B1F, 1'b1, 16'd9, 3'd0, 0, -1);
    test_directed("call_ret",  16'h4002, 16'h1F00, 16'h8007, 16'h0B06, 16'h1F00, 1'b1, 16'd7, 3'd0, 0, 1);
    test_directed("dunder",    16'h0100, 16'h1F00, 16'h1F00, 16'h1F00, 16'h1F00, 1'b0, 16'd0, 3'd1, 0, 0);
    test_directed("dover",     16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h8001, 1'b0, 16'd0, 3'd2, 4, 4);
    test_directed("runder",    16'h0600, 16'h1F00, 16'h1F00, 16'h1F00, 16'h1F00, 1'b0, 16'd0, 3'd3, 0, 0);
    test_directed("rover",     16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 1'b0, 16'd0, 3'd4, 0, 4);
    test_directed("misalign",  16'h2001, 16'h8001, 16'h1F00, 16'h1F00, 16'h1F00, 1'b0, 16'd0, 3'd5, 0, 1);
    test_directed("illegal",   16'h0010, 16'h1F00, 16'h1F00, 16'h1F00, 16'h1F00, 1'b0, 16'd0, 3'd6, 0, 0);
    test_out_stall_reset();
    test_random(40);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
